mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mu0_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// ============================================================================
// mu0_pkg : shared constants for the MU0 memory arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mu0_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic OWNER_CPU  = 1'b0;
   localparam logic OWNER_HOST = 1'b1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin CPU / UART-host arbiter for a single-port RAM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_arbiter
   import mu0_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cpuReq,
   input  logic              cpuRnW,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWData,
   output logic              cpuGnt,
   output logic              cpuValid,
   output logic [DATA_W-1:0] cpuRData,

   input  logic              hostReq,
   input  logic              hostRnW,
   input  logic [ADDR_W-1:0] hostAddr,
   input  logic [DATA_W-1:0] hostWData,
   output logic              hostGnt,
   output logic              hostValid,
   output logic [DATA_W-1:0] hostRData,
   input  logic              hostLock,

   output logic              memEn,
   output logic              memRnW,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,

   output logic [15:0]       cpuStallCnt
);

   logic [1:0]        state;
   logic              owner;
   logic              last_owner;
   logic              rnw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic cpu_elig;
   logic host_elig;
   logic pick_host;

   // The CPU is locked out during a host bulk transfer; otherwise the
   // requester not served last wins a tie.
   assign cpu_elig  = cpuReq & ~hostLock;
   assign host_elig = hostReq;
   assign pick_host = host_elig & (~cpu_elig | (last_owner == OWNER_CPU));

   assign memEn    = (state == ST_ISSUE);
   assign cpuGnt   = memEn & (owner == OWNER_CPU);
   assign hostGnt  = memEn & (owner == OWNER_HOST);
   assign memRnW   = rnw_q;
   assign memAddr  = addr_q;
   assign memWData = wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= OWNER_HOST;
         last_owner  <= OWNER_HOST;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpuRData    <= '0;
         hostRData   <= '0;
         cpuValid    <= 1'b0;
         hostValid   <= 1'b0;
         cpuStallCnt <= 16'd0;
      end else begin
         cpuValid  <= 1'b0;
         hostValid <= 1'b0;
         if (cpuReq && !cpuGnt) begin
            cpuStallCnt <= sat_inc16(cpuStallCnt);
         end
         case (state)
            ST_IDLE: begin
               if (cpu_elig || host_elig) begin
                  owner      <= pick_host;
                  last_owner <= pick_host;
                  rnw_q      <= pick_host ? hostRnW   : cpuRnW;
                  addr_q     <= pick_host ? hostAddr  : cpuAddr;
                  wdata_q    <= pick_host ? hostWData : cpuWData;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (rnw_q) begin
                  if (owner == OWNER_HOST) begin
                     hostRData <= memRData;
                  end else begin
                     cpuRData <= memRData;
                  end
               end
               if (owner == OWNER_HOST) begin
                  hostValid <= 1'b1;
               end else begin
                  cpuValid <= 1'b1;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench with read-data scoreboard
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpuReq = 1'b0, cpuRnW = 1'b0;
   logic [AW-1:0] cpuAddr = '0;
   logic [DW-1:0] cpuWData = '0;
   logic          cpuGnt, cpuValid;
   logic [DW-1:0] cpuRData;
   logic          hostReq = 1'b0, hostRnW = 1'b0, hostLock = 1'b0;
   logic [AW-1:0] hostAddr = '0;
   logic [DW-1:0] hostWData = '0;
   logic          hostGnt, hostValid;
   logic [DW-1:0] hostRData;
   logic          memEn, memRnW;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWData;
   logic [DW-1:0] memRData = '0;
   logic [15:0]   cpuStallCnt;

   int nerr = 0;
   int nchk = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .cpuReq(cpuReq), .cpuRnW(cpuRnW), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
      .cpuGnt(cpuGnt), .cpuValid(cpuValid), .cpuRData(cpuRData),
      .hostReq(hostReq), .hostRnW(hostRnW), .hostAddr(hostAddr), .hostWData(hostWData),
      .hostGnt(hostGnt), .hostValid(hostValid), .hostRData(hostRData), .hostLock(hostLock),
      .memEn(memEn), .memRnW(memRnW), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData), .cpuStallCnt(cpuStallCnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] dflt(input logic [7:0] a);
      return (a == 8'h05) ? 16'h1234 : {8'hA5, a};
   endfunction

   // RAM model: registered read, unwritten locations return a fixed pattern
   logic [15:0]  ram [0:255];
   logic [255:0] wr_mask = '0;
   always @(posedge clk) begin
      if (memEn === 1'b1) begin
         if (memRnW) memRData <= wr_mask[memAddr[7:0]] ? ram[memAddr[7:0]] : dflt(memAddr[7:0]);
         else begin
            ram[memAddr[7:0]]     <= memWData;
            wr_mask[memAddr[7:0]] <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] cpu_q[$];
   logic [15:0] host_q[$];
   logic [15:0] model [0:255];
   logic [15:0] exp_cpu_rd = '0;
   logic [15:0] exp_host_rd = '0;
   logic [15:0] stall_model = '0;
   logic        memen_seen = 1'b0;
   logic        cpugnt_seen = 1'b0;

   always @(negedge clk) begin
      if (cpuValid === 1'b1) begin
         if (cpu_q.size() == 0) chk("cpu_unexpected_valid", 1, 0);
         else chk("cpu_rdata", cpuRData, cpu_q.pop_front());
      end
      if (hostValid === 1'b1) begin
         if (host_q.size() == 0) chk("host_unexpected_valid", 1, 0);
         else chk("host_rdata", hostRData, host_q.pop_front());
      end
      if (memEn === 1'b1) memen_seen = 1'b1;
      if (cpuGnt === 1'b1) cpugnt_seen = 1'b1;
      if (rst) stall_model = '0;
      else if (cpuReq && cpuGnt !== 1'b1 && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input bit host, input bit rnw, input logic [15:0] addr,
                            input logic [15:0] wd, input string tag);
      int  n;
      bit  g, v;
      if (!rnw) model[addr[7:0]] = wd;
      if (host) begin
         if (rnw) exp_host_rd = model[addr[7:0]];
         host_q.push_back(exp_host_rd);
         hostRnW = rnw; hostAddr = addr; hostWData = wd; hostReq = 1'b1;
      end else begin
         if (rnw) exp_cpu_rd = model[addr[7:0]];
         cpu_q.push_back(exp_cpu_rd);
         cpuRnW = rnw; cpuAddr = addr; cpuWData = wd; cpuReq = 1'b1;
      end
      n = 0; g = 0;
      while (!g && n < 20) begin
         step(); n++;
         g = host ? (hostGnt === 1'b1) : (cpuGnt === 1'b1);
      end
      chk({tag, "_gnt_lat"}, n, 1);
      chk({tag, "_mem_addr"}, memAddr, addr);
      chk({tag, "_mem_rnw"}, memRnW, rnw);
      if (!rnw) chk({tag, "_mem_wdata"}, memWData, wd);
      if (host) hostReq = 1'b0; else cpuReq = 1'b0;
      n = 0; v = 0;
      while (!v && n < 20) begin
         step(); n++;
         v = host ? (hostValid === 1'b1) : (cpuValid === 1'b1);
      end
      chk({tag, "_valid_lat"}, n, 2);
   endtask

   initial begin
      int   ng, hg, cg, t0, t1, n;
      logic [3:0] order;
      bit   got;

      for (int i = 0; i < 256; i++) model[i] = dflt(8'(i));

      step(); step();
      chk("rst_cpuGnt", cpuGnt, 0);
      chk("rst_hostGnt", hostGnt, 0);
      chk("rst_valids", {cpuValid, hostValid}, 0);
      chk("rst_memEn", memEn, 0);
      chk("rst_memRnW", memRnW, 0);
      chk("rst_memAddr", memAddr, 0);
      chk("rst_memWData", memWData, 0);
      chk("rst_rdata", {cpuRData, hostRData}, 0);
      chk("rst_stall", cpuStallCnt, 0);
      rst = 1'b0;
      step();

      do_access(1'b0, 1'b1, 16'h0005, 16'h0000, "cpu_rd5");
      do_access(1'b1, 1'b0, 16'h00A0, 16'hCAFE, "host_wr");
      do_access(1'b1, 1'b1, 16'h00A0, 16'h0000, "host_rd");
      do_access(1'b0, 1'b0, 16'h00B1, 16'h5A5A, "cpu_wr");
      do_access(1'b0, 1'b1, 16'h00B1, 16'h0000, "cpu_rdb");
      do_access(1'b1, 1'b1, 16'h00B1, 16'h0000, "host_rdb");
      chk("stall_basic", cpuStallCnt, stall_model);

      // Both requesters together, each held for two accesses
      exp_cpu_rd = model[8'h20]; cpu_q.push_back(exp_cpu_rd); cpu_q.push_back(exp_cpu_rd);
      exp_host_rd = model[8'h30]; host_q.push_back(exp_host_rd); host_q.push_back(exp_host_rd);
      cpuRnW = 1'b1; cpuAddr = 16'h0020; hostRnW = 1'b1; hostAddr = 16'h0030;
      cpuReq = 1'b1; hostReq = 1'b1;
      ng = 0; cg = 0; hg = 0; t0 = 0; t1 = 0; order = '0;
      for (int s = 0; s < 30 && ng < 4; s++) begin
         step();
         if (cpuGnt === 1'b1 || hostGnt === 1'b1) begin
            order[ng] = hostGnt;
            if (ng == 0) t0 = s;
            if (ng == 1) t1 = s;
            ng++;
            if (cpuGnt === 1'b1) begin cg++; if (cg == 2) cpuReq = 1'b0; end
            if (hostGnt === 1'b1) begin hg++; if (hg == 2) hostReq = 1'b0; end
         end
      end
      chk("rr_count", ng, 4);
      chk("rr_order", order, 4'b1010);
      chk("rr_spacing", t1 - t0, 3);
      repeat (4) step();

      // Host bulk lock with a waiting CPU
      exp_cpu_rd = model[8'h40]; cpu_q.push_back(exp_cpu_rd);
      exp_host_rd = model[8'h50];
      cpuRnW = 1'b1; cpuAddr = 16'h0040; hostRnW = 1'b1; hostAddr = 16'h0050;
      cpugnt_seen = 1'b0;
      hostLock = 1'b1; cpuReq = 1'b1; hostReq = 1'b1;
      hg = 0;
      for (int s = 0; s < 200 && hg < 32; s++) begin
         step();
         if (hostGnt === 1'b1) begin hg++; host_q.push_back(exp_host_rd); end
      end
      chk("lock_host_grants", hg, 32);
      chk("lock_no_cpu_gnt", cpugnt_seen, 0);
      chk("lock_stall", cpuStallCnt, stall_model);
      hostLock = 1'b0;
      got = 0; n = 0;
      while (!got && n < 10) begin
         step(); n++;
         got = (cpuGnt === 1'b1) || (hostGnt === 1'b1);
      end
      chk("unlock_cpu_first", {cpuGnt, hostGnt}, 2'b10);
      cpuReq = 1'b0;
      got = 0; n = 0;
      while (!got && n < 10) begin
         step(); n++;
         got = (hostGnt === 1'b1);
      end
      chk("unlock_host_next", got, 1);
      host_q.push_back(exp_host_rd);
      hostReq = 1'b0;
      repeat (4) step();

      // Stall counter saturation
      hostLock = 1'b1; cpuReq = 1'b1;
      repeat (70000) step();
      chk("stall_sat", cpuStallCnt, 16'hFFFF);
      chk("stall_sat_model", cpuStallCnt, stall_model);
      repeat (10) step();
      chk("stall_no_wrap", cpuStallCnt, 16'hFFFF);
      cpuReq = 1'b0; hostLock = 1'b0;
      step();

      // Reset during ISSUE of a host write
      hostRnW = 1'b0; hostAddr = 16'h0060; hostWData = 16'hBEEF; hostReq = 1'b1;
      step();
      chk("abort_in_issue", hostGnt, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_gnt", {cpuGnt, hostGnt}, 0);
      chk("abort_memEn", memEn, 0);
      chk("abort_memAddr", memAddr, 0);
      chk("abort_memWData", memWData, 0);
      chk("abort_stall", cpuStallCnt, 0);
      chk("abort_rdata", {cpuRData, hostRData}, 0);
      hostReq = 1'b0;
      step();
      rst = 1'b0;
      exp_cpu_rd = '0; exp_host_rd = '0;
      memen_seen = 1'b0;
      repeat (6) step();
      chk("abort_no_memEn", memen_seen, 0);
      do_access(1'b1, 1'b1, 16'h0060, 16'h0000, "abort_readback");

      // Request withdrawn before it is ever sampled
      memen_seen = 1'b0;
      hostRnW = 1'b1; hostAddr = 16'h0070;
      hostReq = 1'b1;
      #2 hostReq = 1'b0;
      repeat (6) step();
      chk("withdraw_no_memEn", memen_seen, 0);

      chk("sb_cpu_drained", 32'(cpu_q.size()), 0);
      chk("sb_host_drained", 32'(host_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

`default_nettype wire
